// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter and write sequencer for a shared bank of transparent latches.
// One requester at a time is granted; its data is captured at grant and driven to the
// latch bank with a setup / enable-open / hold sequence before the requester is acked.
// All outputs come from registers so the latch bank sees glitch-free D and EN pins.
module latch_bank_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned EN_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        ack,
   output logic                      busy,
   output logic [DATA_W-1:0]         latch_d,
   output logic                      latch_en
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CntW = 4;

   typedef enum logic [2:0] {StIdle, StSetup, StOpen, StHold, StAck} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [IdxW-1:0]     last_q, last_d;
   logic [IdxW-1:0]     win_q, win_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                en_q, en_d;

   logic                found;
   logic [IdxW-1:0]     pick;
   logic [IdxW-1:0]     idx;

   // Round-robin search starting one past the last winner.
   always_comb begin
      pick  = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned j = 1; j <= NUM_REQ; j++) begin
         idx = IdxW'((32'(last_q) + j) % NUM_REQ);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // Next-state logic for the write sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d = StSetup;
               win_d   = pick;
            end
         end
         StSetup: begin
            state_d = StOpen;
            cnt_d   = CntW'(EN_CYCLES - 1);
         end
         StOpen: begin
            if (cnt_q == '0) begin
               state_d = StHold;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StHold: begin
            state_d = StAck;
         end
         StAck: begin
            state_d = StIdle;
            // Pointer moves only once the transaction has fully completed.
            last_d  = win_q;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Next values of the registered outputs, derived from the state transition.
   always_comb begin
      grant_d = grant_q;
      data_d  = data_q;
      ack_d   = '0;
      // Enable follows OPEN only, so it can never toggle on the same edge as latch_d.
      en_d    = (state_d == StOpen);
      if (state_q == StIdle && found) begin
         grant_d = NUM_REQ'(1) << pick;
         data_d  = req_data[pick*DATA_W +: DATA_W];
      end else if (state_q == StAck) begin
         grant_d = '0;
      end
      if (state_d == StAck) begin
         ack_d = grant_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         last_q  <= IdxW'(NUM_REQ - 1);
         win_q   <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         data_q  <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         win_q   <= win_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         en_q    <= en_d;
      end
   end

   assign grant    = grant_q;
   assign ack      = ack_q;
   assign busy     = (state_q != StIdle);
   assign latch_d  = data_q;
   assign latch_en = en_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Self-checking bench: three arbiter instances (EN_CYCLES 1, 3, 4) checked each cycle
// against a transaction-timeline model built from grant edge numbers.
module tb_latch_bank_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int EN_T [3] = '{1, 3, 4};

   logic          clk = 1'b0;
   logic          rst      [3];
   logic [NR-1:0] req      [3];
   logic [NR*DW-1:0] req_data [3];
   logic [NR-1:0] grant    [3];
   logic [NR-1:0] ack      [3];
   logic          busy     [3];
   logic [DW-1:0] latch_d  [3];
   logic          latch_en [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   latch_bank_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .EN_CYCLES(1)) u0 (
      .clk(clk), .rst(rst[0]), .req(req[0]), .req_data(req_data[0]), .grant(grant[0]),
      .ack(ack[0]), .busy(busy[0]), .latch_d(latch_d[0]), .latch_en(latch_en[0]));
   latch_bank_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .EN_CYCLES(3)) u1 (
      .clk(clk), .rst(rst[1]), .req(req[1]), .req_data(req_data[1]), .grant(grant[1]),
      .ack(ack[1]), .busy(busy[1]), .latch_d(latch_d[1]), .latch_en(latch_en[1]));
   latch_bank_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .EN_CYCLES(4)) u2 (
      .clk(clk), .rst(rst[2]), .req(req[2]), .req_data(req_data[2]), .grant(grant[2]),
      .ack(ack[2]), .busy(busy[2]), .latch_d(latch_d[2]), .latch_en(latch_en[2]));

   // Reference model: each transaction is an edge number e0 plus a winner; every output
   // is a function of the distance d from e0.
   int            edge_n = 0;
   bit            have [3];
   int            e0   [3];
   int            nf   [3];
   int            ptr  [3];
   int            win  [3];
   logic [DW-1:0] md   [3];
   logic [NR-1:0] eg   [3];
   logic [NR-1:0] ea   [3];
   logic          eb   [3];
   logic          ee   [3];
   logic [DW-1:0] ed   [3];

   task automatic model_edge();
      edge_n++;
      for (int k = 0; k < 3; k++) begin
         int d;
         if (rst[k]) begin
            have[k] = 1'b0;
            ptr[k]  = NR - 1;
            nf[k]   = edge_n + 1;
            md[k]   = '0;
         end else begin
            if (have[k] && edge_n == e0[k] + EN_T[k] + 3) ptr[k] = win[k];
            if (edge_n >= nf[k] && req[k] != '0) begin
               int w;
               w = -1;
               for (int j = 1; j <= NR; j++)
                  if (w < 0 && req[k][(ptr[k] + j) % NR]) w = (ptr[k] + j) % NR;
               win[k]  = w;
               have[k] = 1'b1;
               e0[k]   = edge_n;
               nf[k]   = edge_n + EN_T[k] + 4;
               md[k]   = req_data[k][w*DW +: DW];
            end
         end
         d = edge_n - e0[k];
         if (have[k] && d >= 0 && d <= EN_T[k] + 2) begin
            eg[k] = NR'(1) << win[k];
            eb[k] = 1'b1;
         end else begin
            eg[k] = '0;
            eb[k] = 1'b0;
         end
         ee[k] = have[k] && d >= 1 && d <= EN_T[k];
         ea[k] = (have[k] && d == EN_T[k] + 2) ? NR'(1) << win[k] : '0;
         ed[k] = md[k];
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         have[k] = 1'b0; e0[k] = 0; nf[k] = 0; ptr[k] = NR - 1; win[k] = 0; md[k] = '0;
         eg[k] = '0; ea[k] = '0; eb[k] = 1'b0; ee[k] = 1'b0; ed[k] = '0;
      end
      forever begin
         @(posedge clk);
         model_edge();
      end
   end

   function automatic string obs_str(int k);
      return $sformatf("g=%b a=%b b=%b e=%b d=%h", grant[k], ack[k], busy[k], latch_en[k],
                       latch_d[k]);
   endfunction

   function automatic string exp_str(int k);
      return $sformatf("g=%b a=%b b=%b e=%b d=%h", eg[k], ea[k], eb[k], ee[k], ed[k]);
   endfunction

   function automatic int oh_idx(logic [NR-1:0] v);
      for (int i = 0; i < NR; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; req[k] = '0; req_data[k] = '0;
      end
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if ({grant[k], ack[k], busy[k], latch_en[k], latch_d[k]} !== 18'b0) begin
            n_fail++;
            $display("FAIL reset_zero k=%0d got %s want all zero", k, obs_str(k));
         end
         rst[k] = 1'b0;
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if ({grant[k], ack[k], busy[k], latch_en[k], latch_d[k]} !==
             {eg[k], ea[k], eb[k], ee[k], ed[k]}) begin
            n_fail++;
            $display("FAIL reset_idle k=%0d got %s want %s", k, obs_str(k), exp_str(k));
         end
      end
   endtask

   task automatic test_single();
      int en_hi = 0;
      req_data[0][7:0] = 8'hA5;
      req[0] = 4'b0001;
      for (int i = 1; i <= 7; i++) begin
         tick();
         n_checks++;
         if ({grant[0], ack[0], busy[0], latch_en[0], latch_d[0]} !==
             {eg[0], ea[0], eb[0], ee[0], ed[0]}) begin
            n_fail++;
            $display("FAIL single i=%0d got %s want %s", i, obs_str(0), exp_str(0));
         end
         if (i == 1) begin
            n_checks++;
            if ({grant[0], latch_d[0]} !== {4'b0001, 8'hA5}) begin
               n_fail++;
               $display("FAIL single_grant got %s want g=0001 d=a5", obs_str(0));
            end
         end
         if (i == 2) begin
            n_checks++;
            if (latch_en[0] !== 1'b1) begin
               n_fail++;
               $display("FAIL single_en_rise got e=%b want e=1", latch_en[0]);
            end
         end
         if (i == 4) begin
            n_checks++;
            if (ack[0] !== 4'b0001) begin
               n_fail++;
               $display("FAIL single_ack got a=%b want a=0001", ack[0]);
            end
         end
         if (i == 5) begin
            n_checks++;
            if (busy[0] !== 1'b0) begin
               n_fail++;
               $display("FAIL single_idle got b=%b want b=0", busy[0]);
            end
         end
         if (latch_en[0] === 1'b1) en_hi++;
         req[0] = req[0] & ~ack[0];
      end
      n_checks++;
      if (en_hi != 1) begin
         n_fail++;
         $display("FAIL single_en_len got %0d cycles want 1", en_hi);
      end
   endtask

   task automatic test_all_four();
      int            wins [$];
      int            tq   [$];
      logic [DW-1:0] dq   [$];
      logic [NR-1:0] prev_g = '0;
      rst[0] = 1'b1;
      tick(); tick();
      rst[0] = 1'b0;
      req_data[0] = {8'h44, 8'h33, 8'h22, 8'h11};
      req[0] = 4'hF;
      for (int i = 1; i <= 22; i++) begin
         tick();
         n_checks++;
         if ({grant[0], ack[0], busy[0], latch_en[0], latch_d[0]} !==
             {eg[0], ea[0], eb[0], ee[0], ed[0]}) begin
            n_fail++;
            $display("FAIL four i=%0d got %s want %s", i, obs_str(0), exp_str(0));
         end
         if (grant[0] != '0 && prev_g == '0) begin
            wins.push_back(oh_idx(grant[0]));
            dq.push_back(latch_d[0]);
            tq.push_back(i);
         end
         prev_g = grant[0];
         req[0] = req[0] & ~ack[0];
      end
      n_checks++;
      if (wins.size() != 4) begin
         n_fail++;
         $display("FAIL four_count got %0d grants want 4", wins.size());
      end
      for (int j = 0; j < wins.size(); j++) begin
         n_checks++;
         if (wins[j] != j || dq[j] !== 8'(17 * (j + 1))) begin
            n_fail++;
            $display("FAIL four_order j=%0d got w=%0d d=%h want w=%0d d=%h", j, wins[j], dq[j],
                     j, 8'(17 * (j + 1)));
         end
         if (j > 0) begin
            n_checks++;
            if (tq[j] - tq[j-1] != 5) begin
               n_fail++;
               $display("FAIL four_spacing j=%0d got %0d want 5", j, tq[j] - tq[j-1]);
            end
         end
      end
   endtask

   task automatic test_fairness();
      int            wins [$];
      logic [NR-1:0] prev_g = '0;
      logic [NR-1:0] rr = '0;
      int            exp_w [4] = '{0, 2, 0, 2};
      req[0] = 4'b0101;
      for (int i = 1; i <= 30; i++) begin
         tick();
         n_checks++;
         if ({grant[0], ack[0], busy[0], latch_en[0], latch_d[0]} !==
             {eg[0], ea[0], eb[0], ee[0], ed[0]}) begin
            n_fail++;
            $display("FAIL fair i=%0d got %s want %s", i, obs_str(0), exp_str(0));
         end
         if (grant[0] != '0 && prev_g == '0) wins.push_back(oh_idx(grant[0]));
         prev_g = grant[0];
         req[0] = req[0] | rr;
         rr = ack[0];
         req[0] = req[0] & ~ack[0];
      end
      n_checks++;
      if (wins.size() < 4) begin
         n_fail++;
         $display("FAIL fair_count got %0d grants want at least 4", wins.size());
      end
      for (int j = 0; j < wins.size(); j++) begin
         if (j < 4) begin
            n_checks++;
            if (wins[j] != exp_w[j]) begin
               n_fail++;
               $display("FAIL fair_order j=%0d got %0d want %0d", j, wins[j], exp_w[j]);
            end
         end
         if (j > 0) begin
            n_checks++;
            if (wins[j] == wins[j-1]) begin
               n_fail++;
               $display("FAIL fair_repeat j=%0d got %0d twice want alternation", j, wins[j]);
            end
         end
      end
      req[0] = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if ({grant[0], ack[0], busy[0], latch_en[0], latch_d[0]} !==
             {eg[0], ea[0], eb[0], ee[0], ed[0]}) begin
            n_fail++;
            $display("FAIL fair_drain i=%0d got %s want %s", i, obs_str(0), exp_str(0));
         end
      end
   endtask

   task automatic test_en3();
      int en_cnt = 0, en_first = 0, en_last = 0, ack_at = 0;
      req_data[1][7:0] = 8'h3C;
      req[1] = 4'b0001;
      for (int i = 1; i <= 9; i++) begin
         tick();
         n_checks++;
         if ({grant[1], ack[1], busy[1], latch_en[1], latch_d[1]} !==
             {eg[1], ea[1], eb[1], ee[1], ed[1]}) begin
            n_fail++;
            $display("FAIL en3 i=%0d got %s want %s", i, obs_str(1), exp_str(1));
         end
         if (busy[1] === 1'b1) begin
            n_checks++;
            if (latch_d[1] !== 8'h3C) begin
               n_fail++;
               $display("FAIL en3_data i=%0d got %h want 3c", i, latch_d[1]);
            end
         end
         if (latch_en[1] === 1'b1) begin
            en_cnt++;
            if (en_first == 0) en_first = i;
            en_last = i;
         end
         if (ack[1] != '0 && ack_at == 0) ack_at = i;
         req[1] = req[1] & ~ack[1];
      end
      n_checks++;
      if (en_cnt != 3 || en_last - en_first != 2) begin
         n_fail++;
         $display("FAIL en3_len got %0d cycles span %0d want 3 contiguous", en_cnt,
                  en_last - en_first + 1);
      end
      n_checks++;
      if (ack_at != 6) begin
         n_fail++;
         $display("FAIL en3_ack got edge E0+%0d want E0+5", ack_at - 1);
      end
   endtask

   task automatic test_midchange();
      logic [NR-1:0] ack_seen = '0;
      logic [DW-1:0] d_at_ack = '0;
      req_data[0][15:8] = 8'h5A;
      req[0] = 4'b0010;
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_checks++;
         if ({grant[0], ack[0], busy[0], latch_en[0], latch_d[0]} !==
             {eg[0], ea[0], eb[0], ee[0], ed[0]}) begin
            n_fail++;
            $display("FAIL mid i=%0d got %s want %s", i, obs_str(0), exp_str(0));
         end
         if (ack[0] != '0) begin
            ack_seen = ack[0];
            d_at_ack = latch_d[0];
         end
         if (i == 1) req_data[0][15:8] = 8'hFF;
         if (i == 2) req[0] = '0;
      end
      n_checks++;
      if (ack_seen !== 4'b0010 || d_at_ack !== 8'h5A) begin
         n_fail++;
         $display("FAIL mid_ack got a=%b d=%h want a=0010 d=5a", ack_seen, d_at_ack);
      end
   endtask

   task automatic test_reset_open();
      req_data[2][7:0] = 8'h0F;
      req[2] = 4'b0001;
      for (int i = 1; i <= 9; i++) begin
         tick();
         n_checks++;
         if ({grant[2], ack[2], busy[2], latch_en[2], latch_d[2]} !==
             {eg[2], ea[2], eb[2], ee[2], ed[2]}) begin
            n_fail++;
            $display("FAIL rso_pre i=%0d got %s want %s", i, obs_str(2), exp_str(2));
         end
         req[2] = req[2] & ~ack[2];
      end
      req_data[2][15:8] = 8'h77;
      req[2] = 4'b0010;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++;
         if ({grant[2], ack[2], busy[2], latch_en[2], latch_d[2]} !==
             {eg[2], ea[2], eb[2], ee[2], ed[2]}) begin
            n_fail++;
            $display("FAIL rso_open i=%0d got %s want %s", i, obs_str(2), exp_str(2));
         end
      end
      rst[2] = 1'b1;
      req[2] = '0;
      tick();
      n_checks++;
      if ({grant[2], ack[2], busy[2], latch_en[2], latch_d[2]} !== 18'b0) begin
         n_fail++;
         $display("FAIL rso_reset got %s want all zero", obs_str(2));
      end
      rst[2] = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++;
         if (ack[2] !== '0 || busy[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL rso_quiet i=%0d got a=%b b=%b want a=0000 b=0", i, ack[2], busy[2]);
         end
      end
      req_data[2][7:0] = 8'h81;
      req[2] = 4'b0011;
      tick();
      n_checks++;
      if (grant[2] !== 4'b0001 || latch_d[2] !== 8'h81) begin
         n_fail++;
         $display("FAIL rso_first got g=%b d=%h want g=0001 d=81", grant[2], latch_d[2]);
      end
      for (int i = 1; i <= 18; i++) begin
         req[2] = req[2] & ~ack[2];
         tick();
         n_checks++;
         if ({grant[2], ack[2], busy[2], latch_en[2], latch_d[2]} !==
             {eg[2], ea[2], eb[2], ee[2], ed[2]}) begin
            n_fail++;
            $display("FAIL rso_post i=%0d got %s want %s", i, obs_str(2), exp_str(2));
         end
      end
      req[2] = '0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         tick();
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({grant[k], ack[k], busy[k], latch_en[k], latch_d[k]} !==
                {eg[k], ea[k], eb[k], ee[k], ed[k]}) begin
               n_fail++;
               $display("FAIL random k=%0d i=%0d got %s want %s", k, i, obs_str(k),
                        exp_str(k));
            end
            for (int r = 0; r < NR; r++) begin
               if (ack[k][r]) begin
                  req[k][r] = 1'b0;
               end else if (!req[k][r] && $urandom_range(0, 3) == 0) begin
                  req[k][r] = 1'b1;
                  req_data[k][r*DW +: DW] = 8'($urandom);
               end else if ($urandom_range(0, 1) == 0) begin
                  req_data[k][r*DW +: DW] = 8'($urandom);
               end
            end
            rst[k] = ($urandom_range(0, 99) == 0);
         end
      end
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b0;
         req[k] = '0;
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1;
         req[k] = '0;
         req_data[k] = '0;
      end
      test_reset();
      test_single();
      test_all_four();
      test_fairness();
      test_en3();
      test_midchange();
      test_reset_open();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
